btb_update_ctrl: RTL and testbench
==================================

# btb_update_ctrl

Branch-resolution side of the branch target buffer. The block records each fetch-time BTB prediction (hit, way, predicted target) in order in a small in-flight queue. When execute resolves the same instruction, it compares the actual outcome with the prediction, drives the BTB write port, and raises a one-cycle front-end redirect on a mispredict. It sits between the fetch stage (BTB lookup outputs) and the execute stage (branch unit), and is the only writer of the BTB.

## Interface
- `ADDR_WIDTH`, 64, PC/target width.
- `INDEX_WIDTH`, 2, BTB set-index width.
- `BIA_WIDTH`, 60, BTB tag (branch instruction address) width.
- `N`, 4, BTB ways.
- `DEPTH`, 4, in-flight queue entries (power of 2).

Ports:
- `i_clk` input 1: clock, all logic on rising edge.
- `i_arstn` input 1: reset, **synchronous, active-low**.
- `i_pred_valid` input 1: fetch pushes a prediction.
- `i_pred_pc` input ADDR_WIDTH: fetched PC.
- `i_pred_hit` input 1: BTB hit at fetch.
- `i_pred_way` input $clog2(N): BTB way (matching way on hit, PLRU victim on miss).
- `i_pred_target` input ADDR_WIDTH: BTB target at fetch.
- `o_pred_ready` output 1: push accepted this cycle.
- `i_res_valid` input 1: execute resolves the oldest in-flight instruction.
- `i_res_is_branch` input 1: resolved instruction is a branch/jump.
- `i_res_taken` input 1: branch taken.
- `i_res_target` input ADDR_WIDTH: actual taken target.
- `o_branch_taken` output 1: BTB write enable.
- `o_target_addr` output ADDR_WIDTH: BTB write data.
- `o_way_write` output $clog2(N): BTB write way.
- `o_bia_write` output BIA_WIDTH: BTB write tag.
- `o_index_write` output INDEX_WIDTH: BTB write index.
- `o_redirect` output 1: one-cycle flush/redirect pulse.
- `o_redirect_pc` output ADDR_WIDTH: correct next PC.
- `o_mispredict_cnt` output 16: saturating mispredict counter.
- `o_underflow` output 1: sticky error flag, set when a resolve arrives with the queue empty.

## Operation
- **Queue:** circular FIFO of {pc, hit, way, target}, DEPTH entries, with read/write pointers plus a count.
  - Push when `i_pred_valid & o_pred_ready`.
  - `o_pred_ready` = !full & !o_redirect. It depends only on registered state.
- **Resolve:** on `i_res_valid` with the queue non-empty, pop the head entry.
  - Predicted next PC = hit ? target : pc+4.
  - Actual next PC = (is_branch & taken) ? i_res_target : pc+4.
  - Mispredict when predicted ≠ actual.
- **BTB write:** on every resolved taken branch, whether or not it mispredicted (this refreshes PLRU):
  - tag = pc[ADDR_WIDTH-1 : ADDR_WIDTH-BIA_WIDTH];
  - index = pc[ADDR_WIDTH-BIA_WIDTH-1 : ADDR_WIDTH-BIA_WIDTH-INDEX_WIDTH];
  - way = stored way; data = i_res_target.
  - Not-taken branches and non-branches never write (the BTB has no invalidate).
- **Mispredict:**
  - Queue cleared: pointers and count go to 0, and the head pop is subsumed.
  - A push in the same cycle is dropped.
  - `o_redirect_pc` = actual next PC; the counter increments, saturating at 0xFFFF.
- **Simultaneous push and pop without mispredict:** both happen; a push into a full queue is still refused, even with a concurrent pop.
- **Resolve with queue empty:** ignored (no write, no redirect); `o_underflow` is set and stays set until reset.
- **Reset** (`i_arstn`=0 at an edge): queue empty, all outputs 0, counter 0, `o_underflow` 0, `o_pred_ready` 1 from the first cycle after reset release. Reset mid-operation discards all in-flight entries and any pending write or redirect.

## Timing
- Resolve in cycle T → the BTB write port (`o_branch_taken` plus data) is registered and valid in cycle T+1 only, a single-cycle pulse.
- Mispredict resolved in cycle T:
  - `o_redirect` is high with `o_redirect_pc` valid in cycle T+1, a single-cycle pulse.
  - Pushes in T and T+1 are dropped, since `o_pred_ready` = 0 in T+1.
  - Pushes are accepted again from T+2.
- Push in cycle T → the entry is poppable by a resolve in T+1 or later (no same-cycle bypass).
- Back-to-back resolves each cycle → back-to-back write pulses.
- Outputs other than the pulses hold their last value.

## Test plan
- **Cold miss, taken:** push pc=0x1000, hit=0, way=2; resolve taken, target 0x2000 → T+1: write with index=0, bia=0x100, way=2, data=0x2000; redirect to 0x2000; cnt=1.
- **Correct hit:** push pc=0x1000, hit=1, way=2, target=0x2000; resolve taken to 0x2000 → write pulse, no redirect, cnt unchanged.
- **Hit but not taken:** push as above; resolve not-taken → no write; redirect to 0x1004; queue emptied.
- **Flush of younger entries:** push 3 entries, mispredict on the first → next two resolves raise `o_underflow`; push in T+1 refused; push in T+2 accepted.
- **Full queue:** 4 pushes without resolve → `o_pred_ready`=0; a 5th push with a concurrent correct resolve is refused; the next cycle is ready.
- **Reset mid-stream:** 2 entries queued, `i_arstn`=0 for one edge → empty, all outputs 0; a subsequent resolve sets `o_underflow`.

Source files
------------

// File: rtl/btb_update_ctrl_if.sv
// Fetch-prediction, execute-resolve and BTB-write/redirect signals of btb_update_ctrl.
// The slave modport is the controller; the master modport is the fetch/execute side.
interface btb_update_ctrl_if #(
   parameter int unsigned ADDR_WIDTH  = 64,
   parameter int unsigned INDEX_WIDTH = 2,
   parameter int unsigned BIA_WIDTH   = 60,
   parameter int unsigned N           = 4
);
   localparam int unsigned WAY_W = (N > 1) ? $clog2(N) : 1;

   logic                   i_pred_valid;
   logic [ADDR_WIDTH-1:0]  i_pred_pc;
   logic                   i_pred_hit;
   logic [WAY_W-1:0]       i_pred_way;
   logic [ADDR_WIDTH-1:0]  i_pred_target;
   logic                   o_pred_ready;

   logic                   i_res_valid;
   logic                   i_res_is_branch;
   logic                   i_res_taken;
   logic [ADDR_WIDTH-1:0]  i_res_target;

   logic                   o_branch_taken;
   logic [ADDR_WIDTH-1:0]  o_target_addr;
   logic [WAY_W-1:0]       o_way_write;
   logic [BIA_WIDTH-1:0]   o_bia_write;
   logic [INDEX_WIDTH-1:0] o_index_write;
   logic                   o_redirect;
   logic [ADDR_WIDTH-1:0]  o_redirect_pc;
   logic [15:0]            o_mispredict_cnt;
   logic                   o_underflow;

   modport slave (
      input  i_pred_valid, i_pred_pc, i_pred_hit, i_pred_way, i_pred_target,
      output o_pred_ready,
      input  i_res_valid, i_res_is_branch, i_res_taken, i_res_target,
      output o_branch_taken, o_target_addr, o_way_write, o_bia_write, o_index_write,
      output o_redirect, o_redirect_pc, o_mispredict_cnt, o_underflow
   );

   modport master (
      output i_pred_valid, i_pred_pc, i_pred_hit, i_pred_way, i_pred_target,
      input  o_pred_ready,
      output i_res_valid, i_res_is_branch, i_res_taken, i_res_target,
      input  o_branch_taken, o_target_addr, o_way_write, o_bia_write, o_index_write,
      input  o_redirect, o_redirect_pc, o_mispredict_cnt, o_underflow
   );
endinterface

// File: rtl/btb_update_ctrl.sv
// BTB update controller: queues fetch predictions, checks them at resolve time,
// writes the BTB on taken branches and pulses a redirect on mispredict.
module btb_update_ctrl #(
   parameter int unsigned ADDR_WIDTH  = 64,
   parameter int unsigned INDEX_WIDTH = 2,
   parameter int unsigned BIA_WIDTH   = 60,
   parameter int unsigned N           = 4,
   parameter int unsigned DEPTH       = 4
) (
   input logic              i_clk,
   input logic              i_arstn,
   btb_update_ctrl_if.slave bus
);
   localparam int unsigned WAY_W  = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned IDX_LO = ADDR_WIDTH - BIA_WIDTH - INDEX_WIDTH;

   logic [ADDR_WIDTH-1:0]  r_q_pc  [DEPTH];
   logic                   r_q_hit [DEPTH];
   logic [WAY_W-1:0]       r_q_way [DEPTH];
   logic [ADDR_WIDTH-1:0]  r_q_tgt [DEPTH];
   logic [PTR_W-1:0]       r_wptr;
   logic [PTR_W-1:0]       r_rptr;
   logic [PTR_W:0]         r_count;

   logic                   r_branch_taken;
   logic [ADDR_WIDTH-1:0]  r_target_addr;
   logic [WAY_W-1:0]       r_way_write;
   logic [BIA_WIDTH-1:0]   r_bia_write;
   logic [INDEX_WIDTH-1:0] r_index_write;
   logic                   r_redirect;
   logic [ADDR_WIDTH-1:0]  r_redirect_pc;
   logic [15:0]            r_mispredict_cnt;
   logic                   r_underflow;

   logic                   w_full;
   logic                   w_empty;
   logic                   w_ready;
   logic                   w_push;
   logic                   w_pop;
   logic [ADDR_WIDTH-1:0]  w_head_pc;
   logic                   w_head_hit;
   logic [WAY_W-1:0]       w_head_way;
   logic [ADDR_WIDTH-1:0]  w_head_tgt;
   logic [ADDR_WIDTH-1:0]  w_seq_pc;
   logic [ADDR_WIDTH-1:0]  w_pred_next;
   logic [ADDR_WIDTH-1:0]  w_act_next;
   logic                   w_res_taken;
   logic                   w_misp;
   logic                   w_write;

   always_comb begin
      w_full      = (r_count == (PTR_W+1)'(DEPTH));
      w_empty     = (r_count == '0);
      w_ready     = !w_full && !r_redirect;
      w_push      = bus.i_pred_valid && w_ready;
      w_pop       = bus.i_res_valid && !w_empty;
      w_head_pc   = r_q_pc[r_rptr];
      w_head_hit  = r_q_hit[r_rptr];
      w_head_way  = r_q_way[r_rptr];
      w_head_tgt  = r_q_tgt[r_rptr];
      w_seq_pc    = w_head_pc + ADDR_WIDTH'(4);
      w_pred_next = w_head_hit ? w_head_tgt : w_seq_pc;
      w_res_taken = bus.i_res_is_branch && bus.i_res_taken;
      w_act_next  = w_res_taken ? bus.i_res_target : w_seq_pc;
      w_misp      = w_pop && (w_pred_next != w_act_next);
      w_write     = w_pop && w_res_taken;
   end

   // Entry storage needs no reset: validity is carried by the pointers and count.
   always_ff @(posedge i_clk) begin
      if (w_push && !w_misp) begin
         r_q_pc[r_wptr]  <= bus.i_pred_pc;
         r_q_hit[r_wptr] <= bus.i_pred_hit;
         r_q_way[r_wptr] <= bus.i_pred_way;
         r_q_tgt[r_wptr] <= bus.i_pred_target;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_arstn) begin
         r_wptr           <= '0;
         r_rptr           <= '0;
         r_count          <= '0;
         r_branch_taken   <= 1'b0;
         r_target_addr    <= '0;
         r_way_write      <= '0;
         r_bia_write      <= '0;
         r_index_write    <= '0;
         r_redirect       <= 1'b0;
         r_redirect_pc    <= '0;
         r_mispredict_cnt <= '0;
         r_underflow      <= 1'b0;
      end else begin
         // A mispredict flushes every younger entry, including one pushed this cycle.
         if (w_misp) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
         end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
               2'b10:   r_count <= r_count + 1'b1;
               2'b01:   r_count <= r_count - 1'b1;
               default: r_count <= r_count;
            endcase
         end

         r_branch_taken <= w_write;
         if (w_write) begin
            r_target_addr <= bus.i_res_target;
            r_way_write   <= w_head_way;
            r_bia_write   <= w_head_pc[ADDR_WIDTH-1 -: BIA_WIDTH];
            r_index_write <= w_head_pc[IDX_LO +: INDEX_WIDTH];
         end

         r_redirect <= w_misp;
         if (w_misp) begin
            r_redirect_pc <= w_act_next;
            if (r_mispredict_cnt != '1) r_mispredict_cnt <= r_mispredict_cnt + 16'd1;
         end

         if (bus.i_res_valid && w_empty) r_underflow <= 1'b1;
      end
   end

   assign bus.o_pred_ready     = w_ready;
   assign bus.o_branch_taken   = r_branch_taken;
   assign bus.o_target_addr    = r_target_addr;
   assign bus.o_way_write      = r_way_write;
   assign bus.o_bia_write      = r_bia_write;
   assign bus.o_index_write    = r_index_write;
   assign bus.o_redirect       = r_redirect;
   assign bus.o_redirect_pc    = r_redirect_pc;
   assign bus.o_mispredict_cnt = r_mispredict_cnt;
   assign bus.o_underflow      = r_underflow;
endmodule

// File: tb/tb_btb_update_ctrl.sv
// Directed bench for btb_update_ctrl: a vector table for single-cycle behaviour,
// then hand-written flush, full-queue and mid-stream reset sequences.
module tb_btb_update_ctrl;
   logic clk;
   logic arstn;
   int   n_chk;
   int   n_err;

   btb_update_ctrl_if #(.ADDR_WIDTH(64), .INDEX_WIDTH(2), .BIA_WIDTH(60), .N(4)) bus ();

   btb_update_ctrl #(
      .ADDR_WIDTH(64), .INDEX_WIDTH(2), .BIA_WIDTH(60), .N(4), .DEPTH(4)
   ) dut (
      .i_clk   (clk),
      .i_arstn (arstn),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        pv;
      logic [63:0] ppc;
      logic        phit;
      logic [1:0]  pway;
      logic [63:0] ptgt;
      logic        rv;
      logic        rbr;
      logic        rtk;
      logic [63:0] rtgt;
      logic        e_rdy;
      logic        e_bt;
      logic [63:0] e_tgt;
      logic [1:0]  e_way;
      logic [59:0] e_bia;
      logic [1:0]  e_idx;
      logic        e_redir;
      logic [63:0] e_rpc;
      logic [15:0] e_cnt;
      logic        e_uf;
   } vec_t;

   localparam int NV = 17;
   vec_t vecs [NV];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic pv, input logic [63:0] ppc, input logic phit,
                        input logic [1:0] pway, input logic [63:0] ptgt, input logic rv,
                        input logic rbr, input logic rtk, input logic [63:0] rtgt);
      bus.i_pred_valid    = pv;
      bus.i_pred_pc       = ppc;
      bus.i_pred_hit      = phit;
      bus.i_pred_way      = pway;
      bus.i_pred_target   = ptgt;
      bus.i_res_valid     = rv;
      bus.i_res_is_branch = rbr;
      bus.i_res_taken     = rtk;
      bus.i_res_target    = rtgt;
   endtask

   task automatic cyc(input logic pv, input logic [63:0] ppc, input logic phit,
                      input logic [1:0] pway, input logic [63:0] ptgt, input logic rv,
                      input logic rbr, input logic rtk, input logic [63:0] rtgt);
      @(negedge clk);
      drive(pv, ppc, phit, pway, ptgt, rv, rbr, rtk, rtgt);
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [63:0] pc, input logic hit, input logic [1:0] way,
                       input logic [63:0] tgt);
      cyc(1'b1, pc, hit, way, tgt, 1'b0, 1'b0, 1'b0, 64'h0);
   endtask

   task automatic resolve(input logic br, input logic tk, input logic [63:0] tgt);
      cyc(1'b0, 64'h0, 1'b0, 2'd0, 64'h0, 1'b1, br, tk, tgt);
   endtask

   task automatic idle();
      cyc(1'b0, 64'h0, 1'b0, 2'd0, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0);
   endtask

   task automatic check_vec(input string tag, input vec_t v);
      chk({tag, ".ready"}, 64'(bus.o_pred_ready),     64'(v.e_rdy));
      chk({tag, ".wr"},    64'(bus.o_branch_taken),   64'(v.e_bt));
      chk({tag, ".data"},  bus.o_target_addr,          v.e_tgt);
      chk({tag, ".way"},   64'(bus.o_way_write),      64'(v.e_way));
      chk({tag, ".bia"},   64'(bus.o_bia_write),      64'(v.e_bia));
      chk({tag, ".idx"},   64'(bus.o_index_write),    64'(v.e_idx));
      chk({tag, ".redir"}, 64'(bus.o_redirect),       64'(v.e_redir));
      chk({tag, ".rpc"},   bus.o_redirect_pc,          v.e_rpc);
      chk({tag, ".cnt"},   64'(bus.o_mispredict_cnt), 64'(v.e_cnt));
      chk({tag, ".uf"},    64'(bus.o_underflow),      64'(v.e_uf));
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;

      // fields: pv ppc phit pway ptgt | rv rbr rtk rtgt || rdy bt tgt way bia idx redir rpc cnt uf
      vecs[0]  = '{1'b1, 64'h1000, 1'b0, 2'd2, 64'h0,    1'b0, 1'b0, 1'b0, 64'h0,
                   1'b1, 1'b0, 64'h0,    2'd0, 60'h0,   2'd0, 1'b0, 64'h0,    16'd0, 1'b0};
      vecs[1]  = '{1'b0, 64'h0,    1'b0, 2'd0, 64'h0,    1'b1, 1'b1, 1'b1, 64'h2000,
                   1'b0, 1'b1, 64'h2000, 2'd2, 60'h100, 2'd0, 1'b1, 64'h2000, 16'd1, 1'b0};
      vecs[2]  = '{1'b0, 64'h0,    1'b0, 2'd0, 64'h0,    1'b0, 1'b0, 1'b0, 64'h0,
                   1'b1, 1'b0, 64'h2000, 2'd2, 60'h100, 2'd0, 1'b0, 64'h2000, 16'd1, 1'b0};
      vecs[3]  = '{1'b1, 64'h1000, 1'b1, 2'd2, 64'h2000, 1'b0, 1'b0, 1'b0, 64'h0,
                   1'b1, 1'b0, 64'h2000, 2'd2, 60'h100, 2'd0, 1'b0, 64'h2000, 16'd1, 1'b0};
      vecs[4]  = '{1'b0, 64'h0,    1'b0, 2'd0, 64'h0,    1'b1, 1'b1, 1'b1, 64'h2000,
                   1'b1, 1'b1, 64'h2000, 2'd2, 60'h100, 2'd0, 1'b0, 64'h2000, 16'd1, 1'b0};
      vecs[5]  = '{1'b1, 64'h1000, 1'b1, 2'd2, 64'h2000, 1'b0, 1'b0, 1'b0, 64'h0,
                   1'b1, 1'b0, 64'h2000, 2'd2, 60'h100, 2'd0, 1'b0, 64'h2000, 16'd1, 1'b0};
      vecs[6]  = '{1'b0, 64'h0,    1'b0, 2'd0, 64'h0,    1'b1, 1'b1, 1'b0, 64'h0,
                   1'b0, 1'b0, 64'h2000, 2'd2, 60'h100, 2'd0, 1'b1, 64'h1004, 16'd2, 1'b0};
      vecs[7]  = '{1'b0, 64'h0,    1'b0, 2'd0, 64'h0,    1'b0, 1'b0, 1'b0, 64'h0,
                   1'b1, 1'b0, 64'h2000, 2'd2, 60'h100, 2'd0, 1'b0, 64'h1004, 16'd2, 1'b0};
      vecs[8]  = '{1'b1, 64'h12345678, 1'b0, 2'd1, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0,
                   1'b1, 1'b0, 64'h2000, 2'd2, 60'h100, 2'd0, 1'b0, 64'h1004, 16'd2, 1'b0};
      vecs[9]  = '{1'b0, 64'h0,    1'b0, 2'd0, 64'h0,    1'b1, 1'b0, 1'b1, 64'hDEAD0000,
                   1'b1, 1'b0, 64'h2000, 2'd2, 60'h100, 2'd0, 1'b0, 64'h1004, 16'd2, 1'b0};
      vecs[10] = '{1'b1, 64'h12345678, 1'b0, 2'd1, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0,
                   1'b1, 1'b0, 64'h2000, 2'd2, 60'h100, 2'd0, 1'b0, 64'h1004, 16'd2, 1'b0};
      vecs[11] = '{1'b0, 64'h0,    1'b0, 2'd0, 64'h0,    1'b1, 1'b1, 1'b1, 64'hABCD0,
                   1'b0, 1'b1, 64'hABCD0, 2'd1, 60'h1234567, 2'd2, 1'b1, 64'hABCD0, 16'd3, 1'b0};
      vecs[12] = '{1'b0, 64'h0,    1'b0, 2'd0, 64'h0,    1'b0, 1'b0, 1'b0, 64'h0,
                   1'b1, 1'b0, 64'hABCD0, 2'd1, 60'h1234567, 2'd2, 1'b0, 64'hABCD0, 16'd3, 1'b0};
      vecs[13] = '{1'b1, 64'h2000, 1'b1, 2'd3, 64'h3000, 1'b0, 1'b0, 1'b0, 64'h0,
                   1'b1, 1'b0, 64'hABCD0, 2'd1, 60'h1234567, 2'd2, 1'b0, 64'hABCD0, 16'd3, 1'b0};
      vecs[14] = '{1'b1, 64'h2010, 1'b1, 2'd0, 64'h5000, 1'b1, 1'b1, 1'b1, 64'h3000,
                   1'b1, 1'b1, 64'h3000, 2'd3, 60'h200, 2'd0, 1'b0, 64'hABCD0, 16'd3, 1'b0};
      vecs[15] = '{1'b0, 64'h0,    1'b0, 2'd0, 64'h0,    1'b1, 1'b1, 1'b1, 64'h6000,
                   1'b0, 1'b1, 64'h6000, 2'd0, 60'h201, 2'd0, 1'b1, 64'h6000, 16'd4, 1'b0};
      vecs[16] = '{1'b0, 64'h0,    1'b0, 2'd0, 64'h0,    1'b0, 1'b0, 1'b0, 64'h0,
                   1'b1, 1'b0, 64'h6000, 2'd0, 60'h201, 2'd0, 1'b0, 64'h6000, 16'd4, 1'b0};

      arstn = 1'b0;
      drive(1'b0, 64'h0, 1'b0, 2'd0, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst.wr",    64'(bus.o_branch_taken),   64'h0);
      chk("rst.data",  bus.o_target_addr,          64'h0);
      chk("rst.redir", 64'(bus.o_redirect),       64'h0);
      chk("rst.rpc",   bus.o_redirect_pc,          64'h0);
      chk("rst.cnt",   64'(bus.o_mispredict_cnt), 64'h0);
      chk("rst.uf",    64'(bus.o_underflow),      64'h0);
      @(negedge clk);
      arstn = 1'b1;
      #1;
      chk("rst.ready", 64'(bus.o_pred_ready), 64'h1);

      for (int i = 0; i < NV; i++) begin
         cyc(vecs[i].pv, vecs[i].ppc, vecs[i].phit, vecs[i].pway, vecs[i].ptgt,
             vecs[i].rv, vecs[i].rbr, vecs[i].rtk, vecs[i].rtgt);
         check_vec($sformatf("v%0d", i), vecs[i]);
      end

      // Flush: mispredict on the oldest of three; pushes in T and T+1 must be dropped.
      push(64'h100, 1'b0, 2'd1, 64'h0);
      push(64'h200, 1'b0, 2'd1, 64'h0);
      push(64'h300, 1'b0, 2'd1, 64'h0);
      cyc(1'b1, 64'h400, 1'b1, 2'd0, 64'h9000, 1'b1, 1'b1, 1'b1, 64'h5000);
      chk("fl.redir", 64'(bus.o_redirect),       64'h1);
      chk("fl.rpc",   bus.o_redirect_pc,          64'h5000);
      chk("fl.ready", 64'(bus.o_pred_ready),     64'h0);
      chk("fl.wr",    64'(bus.o_branch_taken),   64'h1);
      chk("fl.way",   64'(bus.o_way_write),      64'h1);
      chk("fl.bia",   64'(bus.o_bia_write),      64'h10);
      chk("fl.cnt",   64'(bus.o_mispredict_cnt), 64'd5);
      cyc(1'b1, 64'h500, 1'b1, 2'd0, 64'h9000, 1'b0, 1'b0, 1'b0, 64'h0);
      chk("fl1.redir", 64'(bus.o_redirect),   64'h0);
      chk("fl1.ready", 64'(bus.o_pred_ready), 64'h1);
      chk("fl1.uf",    64'(bus.o_underflow),  64'h0);
      cyc(1'b1, 64'h600, 1'b1, 2'd2, 64'h9000, 1'b1, 1'b0, 1'b0, 64'h0);
      chk("fl2.uf",    64'(bus.o_underflow),    64'h1);
      chk("fl2.redir", 64'(bus.o_redirect),     64'h0);
      chk("fl2.wr",    64'(bus.o_branch_taken), 64'h0);
      resolve(1'b1, 1'b0, 64'h0);
      chk("fl3.redir", 64'(bus.o_redirect),       64'h1);
      chk("fl3.rpc",   bus.o_redirect_pc,          64'h604);
      chk("fl3.cnt",   64'(bus.o_mispredict_cnt), 64'd6);
      resolve(1'b0, 1'b0, 64'h0);
      chk("fl4.uf",    64'(bus.o_underflow), 64'h1);
      chk("fl4.redir", 64'(bus.o_redirect),  64'h0);

      // Full queue: a push alongside a pop while full is refused.
      push(64'h100, 1'b0, 2'd0, 64'h0);
      push(64'h200, 1'b0, 2'd0, 64'h0);
      push(64'h300, 1'b0, 2'd0, 64'h0);
      chk("full3.ready", 64'(bus.o_pred_ready), 64'h1);
      push(64'h400, 1'b0, 2'd0, 64'h0);
      chk("full4.ready", 64'(bus.o_pred_ready), 64'h0);
      cyc(1'b1, 64'h500, 1'b1, 2'd3, 64'h9000, 1'b1, 1'b0, 1'b0, 64'h0);
      chk("full5.ready", 64'(bus.o_pred_ready), 64'h1);
      chk("full5.redir", 64'(bus.o_redirect),   64'h0);
      for (int k = 0; k < 3; k++) begin
         resolve(1'b0, 1'b0, 64'h0);
         chk($sformatf("drain%0d.redir", k), 64'(bus.o_redirect), 64'h0);
      end
      resolve(1'b1, 1'b1, 64'h7777000);
      chk("drain.redir", 64'(bus.o_redirect),       64'h0);
      chk("drain.wr",    64'(bus.o_branch_taken),   64'h0);
      chk("drain.cnt",   64'(bus.o_mispredict_cnt), 64'd6);

      // Reset mid-stream with a would-be mispredict in the reset cycle.
      push(64'h100, 1'b0, 2'd1, 64'h0);
      push(64'h200, 1'b0, 2'd1, 64'h0);
      @(negedge clk);
      arstn = 1'b0;
      drive(1'b0, 64'h0, 1'b0, 2'd0, 64'h0, 1'b1, 1'b1, 1'b1, 64'h8000);
      @(posedge clk);
      #1;
      chk("mr.wr",    64'(bus.o_branch_taken),   64'h0);
      chk("mr.redir", 64'(bus.o_redirect),       64'h0);
      chk("mr.data",  bus.o_target_addr,          64'h0);
      chk("mr.way",   64'(bus.o_way_write),      64'h0);
      chk("mr.bia",   64'(bus.o_bia_write),      64'h0);
      chk("mr.rpc",   bus.o_redirect_pc,          64'h0);
      chk("mr.cnt",   64'(bus.o_mispredict_cnt), 64'h0);
      chk("mr.uf",    64'(bus.o_underflow),      64'h0);
      @(negedge clk);
      arstn = 1'b1;
      drive(1'b0, 64'h0, 1'b0, 2'd0, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0);
      #1;
      chk("mr.ready", 64'(bus.o_pred_ready), 64'h1);
      resolve(1'b1, 1'b1, 64'h8000);
      chk("mr1.uf",    64'(bus.o_underflow),    64'h1);
      chk("mr1.redir", 64'(bus.o_redirect),     64'h0);
      chk("mr1.wr",    64'(bus.o_branch_taken), 64'h0);
      idle();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
